// File: rtl/fp_fma_arbiter.sv
// Round-robin arbiter sharing one fused multiply-add unit among N_REQ requesters,
// with a watchdog that substitutes a quiet-NaN result if the unit never answers.
module fp_fma_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_en_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [2*N_REQ-1:0]       req_op_i,
  input  logic [32*N_REQ-1:0]      req_rs1_i,
  input  logic [32*N_REQ-1:0]      req_rs2_i,
  input  logic [32*N_REQ-1:0]      req_rs3_i,
  output logic [1:0]               fu_op_o,
  output logic [31:0]              fu_rs1_o,
  output logic [31:0]              fu_rs2_o,
  output logic [31:0]              fu_rs3_o,
  output logic                     fu_start_o,
  input  logic                     fu_free_i,
  input  logic                     fu_valid_i,
  input  logic [31:0]              fu_result_i,
  input  logic [2:0]               fu_flags_i,
  output logic                     resp_valid_o,
  output logic [$clog2(N_REQ)-1:0] resp_id_o,
  output logic [31:0]              resp_result_o,
  output logic [2:0]               resp_flags_o,
  input  logic                     resp_ready_i,
  output logic                     timeout_o
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);
  localparam logic [31:0]    QNAN     = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gid;
  logic [CW-1:0]  cnt;
  logic [1:0]     op_q;
  logic [31:0]    rs1_q;
  logic [31:0]    rs2_q;
  logic [31:0]    rs3_q;
  logic [31:0]    res_q;
  logic [2:0]     flags_q;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   cand;
  logic [1:0]     sel_op;
  logic [31:0]    sel_rs1;
  logic [31:0]    sel_rs2;
  logic [31:0]    sel_rs3;
  logic           accept;

  // First valid requester at or above the pointer, wrapping past the top index.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N_REQ))
        cand = cand - (IDW+1)'(N_REQ);
      if (!grant_found && req_valid_i[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_rs1 = '0;
    sel_rs2 = '0;
    sel_rs3 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_op  = req_op_i[2*i +: 2];
        sel_rs1 = req_rs1_i[32*i +: 32];
        sel_rs2 = req_rs2_i[32*i +: 32];
        sel_rs3 = req_rs3_i[32*i +: 32];
      end
    end
  end

  assign accept = (state == IDLE) && fu_free_i && grant_found;

  always_comb begin
    req_ready_o = '0;
    if (accept && clk_en_i && !rst_i)
      req_ready_o[grant_id] = 1'b1;
  end

  // The timeout fires in the last permitted wait cycle; a completion in that same cycle wins.
  assign fu_start_o    = (state == ISSUE) && clk_en_i && !rst_i;
  assign timeout_o     = (state == WAIT) && clk_en_i && !rst_i && !fu_valid_i && (cnt == CNT_LAST);
  assign resp_valid_o  = (state == RESP);
  assign resp_id_o     = gid;
  assign resp_result_o = res_q;
  assign resp_flags_o  = flags_q;
  assign fu_op_o       = op_q;
  assign fu_rs1_o      = rs1_q;
  assign fu_rs2_o      = rs2_q;
  assign fu_rs3_o      = rs3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ptr     <= '0;
      gid     <= '0;
      cnt     <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else if (clk_en_i) begin
      case (state)
        IDLE: begin
          if (accept) begin
            gid   <= grant_id;
            op_q  <= sel_op;
            rs1_q <= sel_rs1;
            rs2_q <= sel_rs2;
            rs3_q <= sel_rs3;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (fu_valid_i) begin
            res_q   <= fu_result_i;
            flags_q <= fu_flags_i;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            res_q   <= QNAN;
            flags_q <= 3'b100;
            state   <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            ptr   <= (gid == ID_LAST) ? '0 : gid + IDW'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
